// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// Optional checksum stage is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int HDR_W = 16;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs four little-endian bytes into a 32-bit word; word_ready marks the 4th byte.
// With IMEM_LOADER_CHECKSUM_EN it also keeps a running 8-bit sum of data bytes.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        word_ready,
  output logic [31:0] word
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  csum
`endif
);

  logic [1:0]      byte_idx;
  logic [2:0][7:0] word_buf;

  // The 4th byte is forwarded directly so the word is available on the accepting edge.
  assign word_ready = en && (byte_idx == 2'd3);
  assign word       = {data, word_buf[2], word_buf[1], word_buf[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word_buf <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      word_buf <= '0;
    end else if (en) begin
      byte_idx <= byte_idx + 2'd1;
      if (byte_idx != 2'd3) word_buf[byte_idx] <= data;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      csum <= '0;
    else if (clr)    csum <= '0;
    else if (en)     csum <= csum + data;
  end
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 32-bit instruction-memory writes; holds the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
  logic [7:0] csum;
`else
  localparam state_t FIN = DONE;
`endif

  state_t           state, state_next;
  logic [7:0]       cnt_lo;
  logic [HDR_W-1:0] count, hdr;
  logic             xfer, asm_en, word_ready, we_next, last_word, finish;
  logic [31:0]      word;

  assign in_ready  = (state != DONE) && (state != ERR);
  assign xfer      = in_valid && in_ready;
  assign hdr       = {in_data, cnt_lo};
  assign asm_en    = xfer && !start && (state == DATA);
  assign last_word = (words_loaded + 16'd1) == count;

  imem_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .en         (asm_en),
    .data       (in_data),
    .word_ready (word_ready),
    .word       (word)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .csum       (csum)
`endif
  );

  always_comb begin
    state_next = state;
    we_next    = 1'b0;
    if (start) begin
      state_next = CNT_LO;
    end else begin
      case (state)
        CNT_LO: if (xfer) state_next = CNT_HI;
        CNT_HI: if (xfer) begin
          if (hdr == '0)                  state_next = FIN;
          else if (int'(hdr) > MAX_WORDS) state_next = ERR;
          else                            state_next = DATA;
        end
        DATA: if (word_ready) begin
          we_next = 1'b1;
          if (last_word) state_next = FIN;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: if (xfer) state_next = (in_data == csum) ? DONE : ERR;
`endif
        default: state_next = state;
      endcase
    end
  end

  // Release waits until the final write strobe has retired.
  assign finish = (state_next == DONE) && !we_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CNT_LO;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      cnt_lo       <= '0;
      count        <= '0;
    end else begin
      state      <= state_next;
      imem_we    <= we_next;
      done       <= finish;
      core_rst_n <= finish;
      error      <= (state_next == ERR);
      if (start) begin
        words_loaded <= '0;
        imem_addr    <= BASE_ADDR;
      end else if (we_next) begin
        imem_addr    <= BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
        imem_wdata   <= word;
        words_loaded <= words_loaded + 16'd1;
      end
      if (!start && xfer && state == CNT_LO) cnt_lo <= in_data;
      if (!start && xfer && state == CNT_HI) count  <= hdr;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by stimulus, checked by a monitor.
module tb_imem_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, core_rst_n, done, error;
  logic [15:0] imem_addr, words_loaded;
  logic [31:0] imem_wdata;

  int   checks = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  logic [15:0] addr_exp;
  logic [7:0]  sum;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {16'd0, imem_addr}, {16'd0, e.addr});
        check("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    wr_t e;
    e.addr = addr_exp;
    e.data = w;
    exp_q.push_back(e);
    addr_exp = addr_exp + 16'd4;
    for (int i = 0; i < 4; i++) begin
      sum = sum + w[8*i +: 8];
      send(w[8*i +: 8], gaps);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    addr_exp = 16'h0000;
    sum = 8'h00;
  endtask

  // Sends the checksum when that stage exists, then waits (bounded) for done.
  task automatic finish_frame(input string name);
    int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(sum, 1'b0);
`endif
    n = 0;
    while (!done && n < 10) begin idle(1); n++; end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [31:0] w3 [3];
    w3[0] = 32'h00300413; w3[1] = 32'h00340413; w3[2] = 32'hDEADBEEF;
    addr_exp = 16'h0000;
    sum = 8'h00;

    // reset values
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {16'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core", {31'd0, core_rst_n}, 32'd0);
    check("rst_flags", {30'd0, done, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // two-word frame, gapless
    send(8'h02, 1'b0); send(8'h00, 1'b0);
    send_word(32'h00300413, 1'b0);
    check("mid_write_we", {31'd0, imem_we}, 32'd1);
    check("mid_write_ready", {31'd0, in_ready}, 32'd1);
    check("mid_write_words", {16'd0, words_loaded}, 32'd1);
    send_word(32'h00340413, 1'b0);
    check("last_write_we", {31'd0, imem_we}, 32'd1);
    check("last_write_core", {31'd0, core_rst_n}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(sum, 1'b0);
`else
    idle(1);
`endif
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_core", {31'd0, core_rst_n}, 32'd1);
    check("t1_words", {16'd0, words_loaded}, 32'd2);
    check("t1_ready", {31'd0, in_ready}, 32'd0);

    // empty frame
    pulse_start();
    check("start_clears_done", {31'd0, done}, 32'd0);
    check("start_core", {31'd0, core_rst_n}, 32'd0);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_core_before_chk", {31'd0, core_rst_n}, 32'd0);
    send(8'h00, 1'b0);
`endif
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_core", {31'd0, core_rst_n}, 32'd1);
    check("t2_words", {16'd0, words_loaded}, 32'd0);

    // oversize header 1025 words
    pulse_start();
    send(8'h01, 1'b0); send(8'h04, 1'b0);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_ready", {31'd0, in_ready}, 32'd0);
    check("t3_core", {31'd0, core_rst_n}, 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    idle(3);
    in_valid = 1'b0;
    check("t3_err_hold", {30'd0, error, done}, 32'd2);
    pulse_start();
    check("t3_clr_error", {31'd0, error}, 32'd0);
    check("t3_clr_ready", {31'd0, in_ready}, 32'd1);

    // three words with random gaps
    send(8'h03, 1'b1); send(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) send_word(w3[i], 1'b1);
    finish_frame("t4_done");
    check("t4_words", {16'd0, words_loaded}, 32'd3);
    check("t4_last_addr", {16'd0, imem_addr}, 32'h8);

    // start mid-word discards partial word
    pulse_start();
    send(8'h01, 1'b0); send(8'h00, 1'b0);
    send(8'h13, 1'b0); send(8'h04, 1'b0);
    pulse_start();
    check("t5_words_clr", {16'd0, words_loaded}, 32'd0);
    send(8'h01, 1'b0); send(8'h00, 1'b0);
    send_word(32'hDDCCBBAA, 1'b0);
    finish_frame("t5_done");
    check("t5_words", {16'd0, words_loaded}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // good and bad checksum on a one-word frame
    pulse_start();
    send(8'h01, 1'b0); send(8'h00, 1'b0);
    send_word(32'h00300413, 1'b0);
    send(8'h47, 1'b0);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_core", {31'd0, core_rst_n}, 32'd1);
    pulse_start();
    send(8'h01, 1'b0); send(8'h00, 1'b0);
    send_word(32'h00300413, 1'b0);
    send(8'h48, 1'b0);
    check("t6_bad_error", {31'd0, error}, 32'd1);
    check("t6_bad_core", {31'd0, core_rst_n}, 32'd0);
    check("t6_bad_done", {31'd0, done}, 32'd0);
`endif

    idle(3);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
